// File: rtl/four_12_12_bias_mem_ld.sv
// -----------------------------------------------------------------------------
// four_12_12_bias_mem_ld
//
// Bias storage for the four_12_12 network stages. It holds DEPTH x WIDTH words
// and has three ways in or out:
//   * a direct write port, used by the host when the loader is idle,
//   * a streaming bulk loader (valid/ready) that fills entries 0..DEPTH-1 in
//     order and pulses load_done once, one cycle after the last word is written,
//   * a registered read port (latency 1) with a valid flag. A write to the
//     read address in the same cycle is forwarded to the read data.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous reset, active-low
//   wr_en       direct write strobe (honoured only while the loader is idle)
//   wr_addr     direct write address; addresses >= DEPTH are dropped
//   wr_data     direct write data
//   rd_en       read request
//   rd_addr     read address; addresses >= DEPTH read as 0
//   rd_data     registered read data; holds its value when rd_en is low
//   rd_valid    rd_data was produced by a read in the previous cycle
//   load_start  single-cycle pulse that starts a bulk load (idle only)
//   load_valid  load_data holds a word
//   load_data   bulk-load word
//   load_ready  the loader accepts a word this cycle
//   load_busy   a bulk load is in progress (includes the done cycle)
//   load_done   one-cycle pulse after the last load word is written
// -----------------------------------------------------------------------------
module four_12_12_bias_mem_ld #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done
);

    // One bit wider than the address so DEPTH itself is representable.
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;

    logic [WIDTH-1:0]  mem [DEPTH];

    // The single internal write port, shared by the direct path and the loader.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [WIDTH-1:0]  rd_word;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // -------------------------------------------------------------------------
    // Loader FSM: next state, write-port arbitration and handshake outputs.
    // The handshake outputs depend on state only, so they are glitch-free and
    // come out of reset at 0 with the state register.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first; a branch that
        // leaves one unassigned would otherwise infer a latch.
        state_next = state;
        count_next = count;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;

        unique case (state)
            S_IDLE: begin
                // A direct write and load_start in the same cycle both take
                // effect: the write lands now, the load starts next cycle.
                mem_we = wr_en && wr_in_range;
                if (load_start) begin
                    state_next = S_LOAD;
                    count_next = '0;
                end
            end

            S_LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = count;
                    mem_wdata = load_data;
                    if (count == LAST) begin
                        count_next = '0;
                        state_next = S_DONE;
                    end else begin
                        count_next = count + ADDR_W'(1);
                    end
                end
            end

            S_DONE: begin
                load_done  = 1'b1;
                load_busy  = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage. A reset must leave every bias at zero, so the array is built
    // from resettable flops rather than a RAM macro.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clearing the whole array on reset is deliberate here; it is
        // what rules out mapping this storage onto a RAM without reset.
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read port: write-first forwarding, out-of-range reads return 0.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (mem_we && (mem_waddr == rd_addr)) begin
                rd_word = mem_wdata;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_four_12_12_bias_mem_ld.sv
// -----------------------------------------------------------------------------
// Testbench for four_12_12_bias_mem_ld.
// Two instances share one stimulus stream: inst_a (WIDTH=32, DEPTH=4) gets the
// low two address bits, inst_b (WIDTH=16, DEPTH=5) the full three bits and the
// low half of every data word. A behavioural model of each table is stepped on
// every rising edge and compared against both instances on every falling edge;
// directed sections also pin a few hand-computed values.
// -----------------------------------------------------------------------------
module tb_four_12_12_bias_mem_ld;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;

    logic [31:0] rd_data_a;
    logic        rd_valid_a;
    logic        load_ready_a;
    logic        load_busy_a;
    logic        load_done_a;

    logic [15:0] rd_data_b;
    logic        rd_valid_b;
    logic        load_ready_b;
    logic        load_busy_b;
    logic        load_done_b;

    int checks   = 0;
    int failures = 0;

    four_12_12_bias_mem_ld #(.WIDTH(32), .DEPTH(4)) inst_a (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr[1:0]),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr[1:0]),
        .rd_data    (rd_data_a),
        .rd_valid   (rd_valid_a),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_a),
        .load_busy  (load_busy_a),
        .load_done  (load_done_a)
    );

    four_12_12_bias_mem_ld #(.WIDTH(16), .DEPTH(5)) inst_b (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data[15:0]),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_b),
        .rd_valid   (rd_valid_b),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data[15:0]),
        .load_ready (load_ready_b),
        .load_busy  (load_busy_b),
        .load_done  (load_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: per instance, a plain array of words plus the loader
    // phase and the index of the next word to load.
    // -------------------------------------------------------------------------
    typedef enum int {M_IDLE, M_LOAD, M_DONE} phase_t;

    logic [31:0] m_mem [2][5];
    logic [31:0] m_rd  [2];
    logic        m_rv  [2];
    phase_t      m_ph  [2];
    int          m_idx [2];
    bit          started = 1'b0;

    int          m_depth;
    int          m_ra;
    int          m_wa;
    int          m_a;
    bit          m_we;
    logic [31:0] m_v;
    logic [31:0] m_mask;

    always @(posedge clk) begin
        started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_depth = (k == 0) ? 4 : 5;
            m_mask  = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            m_ra    = (k == 0) ? int'(rd_addr[1:0]) : int'(rd_addr);
            m_wa    = (k == 0) ? int'(wr_addr[1:0]) : int'(wr_addr);
            if (!reset) begin
                for (int i = 0; i < 5; i++) m_mem[k][i] = '0;
                m_rd[k]  = '0;
                m_rv[k]  = 1'b0;
                m_ph[k]  = M_IDLE;
                m_idx[k] = 0;
            end else begin
                m_we = 1'b0;
                m_a  = 0;
                m_v  = '0;
                if (m_ph[k] == M_IDLE && wr_en && m_wa < m_depth) begin
                    m_we = 1'b1;
                    m_a  = m_wa;
                    m_v  = wr_data & m_mask;
                end else if (m_ph[k] == M_LOAD && load_valid) begin
                    m_we = 1'b1;
                    m_a  = m_idx[k];
                    m_v  = load_data & m_mask;
                end
                m_rv[k] = rd_en;
                if (rd_en) begin
                    if (m_ra >= m_depth)           m_rd[k] = '0;
                    else if (m_we && m_a == m_ra)  m_rd[k] = m_v;
                    else                           m_rd[k] = m_mem[k][m_ra];
                end
                if (m_we) m_mem[k][m_a] = m_v;
                case (m_ph[k])
                    M_IDLE: if (load_start) begin
                        m_ph[k]  = M_LOAD;
                        m_idx[k] = 0;
                    end
                    M_LOAD: if (load_valid) begin
                        m_idx[k]++;
                        if (m_idx[k] == m_depth) begin
                            m_idx[k] = 0;
                            m_ph[k]  = M_DONE;
                        end
                    end
                    default: m_ph[k] = M_IDLE;
                endcase
            end
        end
    end

    // Compare process: both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("a.rd_data",    rd_data_a,                 m_rd[0]);
            check("a.rd_valid",   32'(rd_valid_a),           32'(m_rv[0]));
            check("a.load_ready", 32'(load_ready_a),         32'(m_ph[0] == M_LOAD));
            check("a.load_busy",  32'(load_busy_a),          32'(m_ph[0] != M_IDLE));
            check("a.load_done",  32'(load_done_a),          32'(m_ph[0] == M_DONE));
            check("b.rd_data",    {16'h0000, rd_data_b},     m_rd[1]);
            check("b.rd_valid",   32'(rd_valid_b),           32'(m_rv[1]));
            check("b.load_ready", 32'(load_ready_b),         32'(m_ph[1] == M_LOAD));
            check("b.load_busy",  32'(load_busy_b),          32'(m_ph[1] != M_IDLE));
            check("b.load_done",  32'(load_done_b),          32'(m_ph[1] == M_DONE));
        end
    end

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam bit [5:0] VALID_PAT = 6'b101101;   // applied bit 0 first

    int accepts_a;
    int n_words;

    initial begin
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        cyc();
        cyc();
        check("reset.load_busy_a", 32'(load_busy_a), 32'd0);
        check("reset.rd_valid_a",  32'(rd_valid_a),  32'd0);
        reset = 1'b1;

        // Every entry reads 0 after reset, one cycle after each request.
        for (int i = 0; i < 4; i++) begin
            rd_en   = 1'b1;
            rd_addr = 3'(i);
            cyc();
            check("reset_read.data_a",  rd_data_a,        32'd0);
            check("reset_read.valid_a", 32'(rd_valid_a),  32'd1);
        end
        rd_en = 1'b0;
        cyc();
        check("idle.rd_valid_a", 32'(rd_valid_a), 32'd0);

        // Direct write then read; then same-cycle write and read (bypass).
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 32'hDEAD_BEEF;
        cyc();
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 3'd2;
        cyc();
        check("direct.addr2_a", rd_data_a,             32'hDEAD_BEEF);
        check("direct.addr2_b", {16'h0, rd_data_b},    32'h0000_BEEF);
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 32'h0000_0011;
        rd_addr = 3'd1;
        cyc();
        check("bypass.addr1_a", rd_data_a,             32'h0000_0011);
        check("bypass.addr1_b", {16'h0, rd_data_b},    32'h0000_0011);
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Bulk load with gaps; a direct write and a second load_start land in
        // the first stall cycle and must both be ignored.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        accepts_a  = 0;
        n_words    = 0;
        for (int j = 0; j < 6; j++) begin
            load_valid = VALID_PAT[j];
            load_data  = 32'hA0 + 32'(n_words);
            if (j == 1) begin
                wr_en      = 1'b1;
                wr_addr    = 3'd0;
                wr_data    = 32'hFF;
                load_start = 1'b1;
            end
            if (load_ready_a && load_valid) accepts_a++;
            cyc();
            if (VALID_PAT[j]) n_words++;
            wr_en      = 1'b0;
            load_start = 1'b0;
        end
        check("load.accepts_a", 32'(accepts_a), 32'd4);
        check("load.done_a",    32'(load_done_a), 32'd1);
        check("load.busy_a",    32'(load_busy_a), 32'd1);
        // Fifth word only matters to the 5-deep instance.
        load_valid = 1'b1;
        load_data  = 32'hA4;
        cyc();
        load_valid = 1'b0;
        check("load.done_a_over", 32'(load_done_a), 32'd0);
        check("load.done_b",      32'(load_done_b), 32'd1);
        for (int i = 0; i < 5; i++) begin
            rd_en   = 1'b1;
            rd_addr = 3'(i);
            cyc();
            if (i < 4) check("load.read_a", rd_data_a, 32'hA0 + 32'(i));
            check("load.read_b", {16'h0, rd_data_b}, 32'hA0 + 32'(i));
        end
        rd_addr = 3'd6;
        cyc();
        check("oob.read_b",  {16'h0, rd_data_b}, 32'd0);
        check("oob.valid_b", 32'(rd_valid_b),    32'd1);
        rd_en = 1'b0;

        // Reset in the middle of a load: no done pulse, everything cleared.
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'h55;
        cyc();
        load_data  = 32'h66;
        cyc();
        load_valid = 1'b0;
        reset      = 1'b0;
        cyc();
        reset = 1'b1;
        check("abort.busy_a", 32'(load_busy_a), 32'd0);
        check("abort.done_a", 32'(load_done_a), 32'd0);
        cyc();
        check("abort.done_a_next", 32'(load_done_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd_en   = 1'b1;
            rd_addr = 3'(i);
            cyc();
            check("abort.read_b", {16'h0, rd_data_b}, 32'd0);
            if (i < 4) check("abort.read_a", rd_data_a, 32'd0);
        end
        rd_en = 1'b0;

        // Randomised traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            reset      = ($urandom_range(0, 99) != 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = $urandom;
            rd_en      = ($urandom_range(0, 1) == 0);
            rd_addr    = 3'($urandom_range(0, 7));
            load_start = ($urandom_range(0, 11) == 0);
            load_valid = ($urandom_range(0, 1) == 0);
            load_data  = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
